pipe_chain: RTL and testbench
=============================

Name: pipe_chain

Overview:
- Parametrised, reusable pipeline-register chain.
- Replaces the hand-written IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers, whose stall and bubble logic is duplicated per stage.
- Provides DEPTH slots of WIDTH-bit payload, each with a valid bit, per-stage stall and flush, downstream back-pressure, bubble collapse, and occupancy and stall counters.
- Sits between processor stages; stage taps feed forwarding and hazard logic.

Parameters:
- DEPTH, 4: number of register stages (≥1).
- WIDTH, 32: payload bits per stage.
- ZERO_BUBBLE, 1: 1 = payload zeroed when a stage receives a bubble or flush; 0 = payload left unchanged, only valid cleared.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an entry.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage 0 accepts this cycle.
- stall_req  in  DEPTH  bit i: stage i must not advance (e.g. load-use, mul stall).
- flush  in  DEPTH  bit i: stage i is invalid after the edge (branch/jump squash).
- out_ready  in  1  consumer accepts the last stage.
- out_valid  out  1  last stage holds valid data.
- out_data  out  WIDTH  last stage payload.
- stage_valid  out  DEPTH  valid bit per stage.
- stage_data  out  DEPTH*WIDTH  payload per stage; stage 0 in the most-significant slice.
- occupancy  out  $clog2(DEPTH+1)  count of valid stages.
- stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0, saturating.

Behaviour:
- Indexing: stage 0 is nearest the input; stage DEPTH-1 drives out_*. All vectors are declared [0:DEPTH-1].
- Reset is synchronous: all valid bits 0, all payloads 0, stall_cnt 0. Consequently out_valid=0, out_data=0, occupancy=0, in_ready=1 in the cycle after reset. Reset overrides every other input, including mid-stream.
- Effective valid: v_eff[i] = valid[i] & ~flush[i]. A flushed stage never back-pressures.
- Block chain (combinational, evaluated downstream to upstream):
  - blk[DEPTH-1] = stall_req[DEPTH-1] | (v_eff[DEPTH-1] & ~out_ready)
  - blk[i] = stall_req[i] | (v_eff[i] & blk[i+1])
- in_ready = ~blk[0]. Acceptance occurs when in_valid & in_ready.
- Per-stage update at the clock edge, in priority order:
  1. flush[i]: valid ← 0; payload zeroed if ZERO_BUBBLE.
  2. blk[i]: hold valid and payload.
  3. Otherwise load from the source: stage i-1 for i>0, the input for i=0.
     - valid ← src_valid & ~src_blk & ~src_flush.
     - If the result is 0 (bubble), payload is zeroed if ZERO_BUBBLE, else unchanged.
     - For the input source: src_valid = in_valid, src_blk = 0, src_flush = 0.
- Bubble collapse: an empty stage is never blocked by a stalled downstream stage, so upstream entries advance into gaps.
- A stall_req on an empty stage keeps it empty and blocks upstream.
- Latency: DEPTH cycles from acceptance to out_valid with no stalls. Throughput is 1 entry/cycle.
- Simultaneous acceptance and flush[0]: the entry is dropped; it is still counted as accepted.
- Output transfer occurs when out_valid & out_ready & ~flush[DEPTH-1]. A flushed output is not transferred.
- Ordering: entries leave in acceptance order; no duplication; no loss except by flush.
- occupancy = popcount(valid), registered (it reflects register state, not the next state).
- stall_cnt increments when in_valid & ~in_ready, and saturates at 2^CNT_W-1.
- DEPTH=1: the block chain degenerates to blk[0] = stall_req[0] | (v_eff[0] & ~out_ready).

Decomposition:
- Package pipe_pkg holds:
  - the function popcount(valid vector);
  - the function sat_inc(count, width);
  - localparam helper OCC_W(depth) = $clog2(depth+1).
- Sub-module pipe_slot holds one stage:
  - inputs: src_valid, src_data, blk, flush, reset;
  - outputs: valid, data;
  - parameters: WIDTH, ZERO_BUBBLE.
- pipe_chain generates DEPTH pipe_slot instances and contains the block chain and counters.

Test Plan (DEPTH=4, WIDTH=32, CNT_W=4 unless stated):
1. Stream 0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_ready=1 → out_valid rises 4 cycles after the first acceptance; out_data is 0x11..0x44 in order; occupancy reaches 4; in_ready stays 1.
2. Full pipe with out_ready=1; stall_req[1]=1 for 2 cycles → stages 0 and 1 hold; stage 2 receives bubbles (stage 2 data=0 with ZERO_BUBBLE=1); in_ready=0 for 2 cycles with in_valid=1 → stall_cnt=2; order is preserved afterwards.
3. Entries only in stages 0 and 3, out_ready=0 → stage 0 advances to stage 1, then 2; in_ready stays 1 until occupancy=4, then in_ready=0.
4. Full pipe, out_ready=0, flush on stages 0 and 1 → next cycle stage_valid = {0,0,1,1}, stage 0/1 data=0, in_ready=1; no output transfer occurs.
5. Reset asserted mid-stream with 3 valid entries → next cycle stage_valid all 0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1.
6. in_valid=1 with stall_req[0]=1 held for 20 cycles → stall_cnt saturates at 15. Rerun with ZERO_BUBBLE=0: bubble stages keep their prior payload with valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared helpers for the pipeline-register chain:
// occupancy width, popcount and saturating increment.
package pipe_pkg;

  localparam int unsigned MAX_DEPTH = 64;

  function automatic int unsigned OCC_W(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned popcount(
    input logic [MAX_DEPTH-1:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [63:0] sat_inc(
    input logic [63:0] c,
    input int unsigned w
  );
    logic [63:0] mx;
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (c >= mx) ? mx : c + 64'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register stage: valid bit plus payload,
// with flush over hold over load priority.
module pipe_slot #(
  parameter int unsigned WIDTH       = 32,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             blk,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      if (ZERO_BUBBLE) data_d = '0;
    end else if (!blk) begin
      valid_d = src_valid;
      if (src_valid) begin
        data_d = src_data;
      end else if (ZERO_BUBBLE) begin
        data_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_chain.sv
// Parametrised pipeline-register chain with per-stage
// stall/flush, back-pressure, bubble collapse and counters.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WIDTH       = 32,
  parameter bit          ZERO_BUBBLE = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic [0:DEPTH-1]          stall_req,
  input  logic [0:DEPTH-1]          flush,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [0:DEPTH-1]          stage_valid,
  output logic [DEPTH*WIDTH-1:0]    stage_data,
  output logic [OCC_W(DEPTH)-1:0]   occupancy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned OW = OCC_W(DEPTH);

  logic [0:DEPTH-1] valid;
  logic [0:DEPTH-1] v_eff;
  logic [0:DEPTH-1] blk;
  logic [0:DEPTH-1] src_valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign v_eff = valid & ~flush;

  // Walk from the output back: a stage is blocked only
  // if it holds live data and everything below it is.
  always_comb begin
    logic down;
    blk  = '0;
    down = ~out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      blk[i] = stall_req[i] | (v_eff[i] & down);
      down   = blk[i];
    end
  end

  assign in_ready = ~blk[0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign src_valid[g] = in_valid;
      assign src_data[g]  = in_data;
    end else begin : g_body
      assign src_valid[g] = valid[g-1] & ~blk[g-1]
                          & ~flush[g-1];
      assign src_data[g]  = data[g-1];
    end

    pipe_slot #(
      .WIDTH      (WIDTH),
      .ZERO_BUBBLE(ZERO_BUBBLE)
    ) u_slot (
      .clock    (clock),
      .reset    (reset),
      .src_valid(src_valid[g]),
      .src_data (src_data[g]),
      .blk      (blk[g]),
      .flush    (flush[g]),
      .valid    (valid[g]),
      .data     (data[g])
    );

    assign stage_data[(DEPTH-g)*WIDTH-1 -: WIDTH] = data[g];
  end

  assign stage_valid = valid;
  assign out_valid   = valid[DEPTH-1];
  assign out_data    = data[DEPTH-1];
  assign occupancy   = OW'(popcount(MAX_DEPTH'(valid)));

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid & ~in_ready) begin
      cnt_d = CNT_W'(sat_inc(64'(cnt_q), CNT_W));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: directed scenarios plus random
// traffic against a behavioural model, both bubble modes.
module tb_pipe_chain;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         out_ready;
  logic [0:3]   stall_req;
  logic [0:3]   flush;

  logic         a_in_ready, b_in_ready;
  logic         a_out_valid, b_out_valid;
  logic [31:0]  a_out_data, b_out_data;
  logic [0:3]   a_sv, b_sv;
  logic [127:0] a_sd, b_sd;
  logic [2:0]   a_occ, b_occ;
  logic [3:0]   a_cnt, b_cnt;

  int errors;
  int checks;

  logic        mv [4];
  logic [31:0] md [2][4];
  int unsigned mcnt;

  pipe_chain #(
    .DEPTH(4), .WIDTH(32), .ZERO_BUBBLE(1'b1), .CNT_W(4)
  ) dut_a (
    .clock(clk), .reset(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready),
    .stall_req(stall_req), .flush(flush),
    .out_ready(out_ready),
    .out_valid(a_out_valid), .out_data(a_out_data),
    .stage_valid(a_sv), .stage_data(a_sd),
    .occupancy(a_occ), .stall_cnt(a_cnt)
  );

  pipe_chain #(
    .DEPTH(4), .WIDTH(32), .ZERO_BUBBLE(1'b0), .CNT_W(4)
  ) dut_b (
    .clock(clk), .reset(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready),
    .stall_req(stall_req), .flush(flush),
    .out_ready(out_ready),
    .out_valid(b_out_valid), .out_data(b_out_data),
    .stage_valid(b_sv), .stage_data(b_sd),
    .occupancy(b_occ), .stall_cnt(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A live stage is blocked when the run of live stages
  // below it ends in a stall request, or reaches the
  // output while the consumer is not ready.
  function automatic logic [0:3] mblk();
    logic [0:3] b;
    for (int i = 0; i < 4; i++) begin
      logic stop;
      logic found;
      if (stall_req[i]) begin
        b[i] = 1'b1;
      end else if (!(mv[i] && !flush[i])) begin
        b[i] = 1'b0;
      end else begin
        found = 1'b0;
        stop  = !out_ready;
        for (int j = i + 1; j < 4; j++) begin
          if (!found) begin
            if (stall_req[j]) begin
              found = 1'b1;
              stop  = 1'b1;
            end else if (!(mv[j] && !flush[j])) begin
              found = 1'b1;
              stop  = 1'b0;
            end
          end
        end
        b[i] = stop;
      end
    end
    return b;
  endfunction

  task automatic model_edge();
    logic [0:3]  b;
    logic        ov [4];
    logic [31:0] od [2][4];
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mv[i]    = 1'b0;
        md[0][i] = '0;
        md[1][i] = '0;
      end
      mcnt = 0;
    end else begin
      b  = mblk();
      if (in_valid && b[0] && mcnt < 15) mcnt++;
      ov = mv;
      od = md;
      for (int i = 0; i < 4; i++) begin
        logic sv;
        if (i == 0) sv = in_valid;
        else sv = ov[i-1] && !b[i-1] && !flush[i-1];
        if (flush[i]) begin
          mv[i]    = 1'b0;
          md[0][i] = '0;
        end else if (!b[i]) begin
          mv[i] = sv;
          for (int d = 0; d < 2; d++) begin
            if (sv) md[d][i] = (i == 0) ? in_data : od[d][i-1];
            else if (d == 0) md[d][i] = '0;
          end
        end
      end
    end
  endtask

  function automatic logic [127:0] mpack(input int d);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[(4-i)*32-1 -: 32] = md[d][i];
    return r;
  endfunction

  function automatic logic [0:3] mvv();
    logic [0:3] v;
    for (int i = 0; i < 4; i++) v[i] = mv[i];
    return v;
  endfunction

  function automatic int unsigned mocc();
    int unsigned n;
    n = 0;
    for (int i = 0; i < 4; i++) n += 32'(mv[i]);
    return n;
  endfunction

  task automatic check_state();
    chk("valid_a", a_sv, mvv());
    chk("data_a", a_sd, mpack(0));
    chk("occ_a", a_occ, mocc());
    chk("cnt_a", a_cnt, mcnt);
    chk("outv_a", a_out_valid, mv[3]);
    chk("outd_a", a_out_data, md[0][3]);
    chk("valid_b", b_sv, mvv());
    chk("data_b", b_sd, mpack(1));
    chk("occ_b", b_occ, mocc());
    chk("cnt_b", b_cnt, mcnt);
    chk("outd_b", b_out_data, md[1][3]);
  endtask

  task automatic tick();
    logic [0:3] b;
    #1;
    b = mblk();
    chk("in_ready_a", a_in_ready, !b[0]);
    chk("in_ready_b", b_in_ready, !b[0]);
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    mcnt      = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    stall_req = '0;
    flush     = '0;

    @(posedge clk);
    model_edge();
    #1;
    check_state();
    rst = 1'b0;
    #1;
    chk("rst_outv", a_out_valid, 1'b0);
    chk("rst_outd", a_out_data, 32'h0);
    chk("rst_occ", a_occ, 3'd0);
    chk("rst_rdy", a_in_ready, 1'b1);

    // stream four entries
    in_valid = 1'b1;
    in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_data = 32'h33; tick();
    in_data = 32'h44; tick();
    chk("t1_outv", a_out_valid, 1'b1);
    chk("t1_out0", a_out_data, 32'h11);
    chk("t1_occ", a_occ, 3'd4);
    in_valid = 1'b0;
    tick(); chk("t1_out1", a_out_data, 32'h22);
    tick(); chk("t1_out2", a_out_data, 32'h33);
    tick(); chk("t1_out3", a_out_data, 32'h44);
    tick(); chk("t1_drain", a_out_valid, 1'b0);

    // stall stage 1 in a full pipe
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = 32'h100 + 32'(k);
      tick();
    end
    in_data      = 32'h105;
    stall_req[1] = 1'b1;
    tick();
    tick();
    chk("t2_cnt", a_cnt, 4'd2);
    chk("t2_sv", a_sv, 4'b1100);
    chk("t2_s2a", a_sd[63:32], 32'h0);
    chk("t2_s2b", b_sd[63:32], 32'h102);
    chk("t2_svb", b_sv, 4'b1100);
    stall_req = '0;
    tick();
    chk("t2_resume", a_sd, {32'h105, 32'h104, 32'h103, 32'h0});
    in_valid = 1'b0;
    repeat (4) tick();

    // bubble collapse with a stopped consumer
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA1; tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("t3_x", a_sv, 4'b0001);
    in_valid = 1'b1; in_data = 32'hA2; tick();
    chk("t3_xy", a_sv, 4'b1001);
    in_valid = 1'b0;
    tick(); tick();
    chk("t3_adv", a_sv, 4'b0011);
    in_valid = 1'b1;
    in_data = 32'hA3; tick();
    in_data = 32'hA4; tick();
    chk("t3_full", a_occ, 3'd4);
    in_data = 32'hA5;
    #1;
    chk("t3_rdy", a_in_ready, 1'b0);

    // flush the two upstream stages
    in_valid = 1'b0;
    flush    = 4'b1100;
    tick();
    flush = '0;
    #1;
    chk("t4_sv", a_sv, 4'b0011);
    chk("t4_zero", a_sd[127:64], 64'h0);
    chk("t4_rdy", a_in_ready, 1'b1);
    chk("t4_hold", a_out_data, 32'hA1);

    // stall counter saturation
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    in_data      = 32'hB0;
    stall_req[0] = 1'b1;
    repeat (20) tick();
    chk("t6_sat_a", a_cnt, 4'd15);
    chk("t6_sat_b", b_cnt, 4'd15);
    chk("t6_empty", a_sv, 4'b0000);

    // reset with three live entries
    stall_req = '0;
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_data = 32'hC0 + 32'(k);
      tick();
    end
    chk("t5_occ", a_occ, 3'd3);
    in_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("t5_sv", a_sv, 4'b0000);
    chk("t5_outd", a_out_data, 32'h0);
    chk("t5_occ0", a_occ, 3'd0);
    chk("t5_cnt", a_cnt, 4'd0);
    chk("t5_rdy", a_in_ready, 1'b1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        stall_req[i] = ($urandom_range(0, 7) == 0);
        flush[i]     = ($urandom_range(0, 15) == 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
